simon_input_reader: RTL and testbench

//  Player-input side of the Simon game: reads the four active-low Simon buttons, debounces them,

---
 rtl/simon_input_reader.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_simon_input_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_input_reader.sv
// simon_input_reader
// Player-input side of the Simon game. It synchronises and debounces the four
// active-low buttons and encodes the held button as a colour. Each accepted
// press is checked against the stored sequence, and the round result is
// reported as pass, fail or timeout.
// Build option: define SIMON_STRICT_CHORD_EN to fail the round immediately when
// two or more buttons are seen together while a press is being taken or held.

module simon_input_reader #(
  parameter  int unsigned DEBOUNCE_CYCLES = 500000,
  parameter  int unsigned TIMEOUT_CYCLES  = 250000000,
  parameter  int unsigned MAX_LEN         = 32,
  localparam int unsigned IDX_W           = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SimonBtnTL,
  input  logic             SimonBtnTR,
  input  logic             SimonBtnBL,
  input  logic             SimonBtnBR,
  input  logic             start,
  input  logic [IDX_W:0]   seq_len,
  output logic [IDX_W-1:0] exp_idx,
  input  logic [1:0]       exp_color,
  output logic [1:0]       led_color,
  output logic             led_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_SAT   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_SAT  = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_PRESS = 3'd1;
  localparam logic [2:0] S_DB_DOWN    = 3'd2;
  localparam logic [2:0] S_HELD       = 3'd3;
  localparam logic [2:0] S_DB_UP      = 3'd4;

  // Raw buttons, bit index equals colour code: TL=0, TR=1, BL=2, BR=3.
  logic [3:0] btn_raw_c;
  assign btn_raw_c = {SimonBtnBR, SimonBtnBL, SimonBtnTR, SimonBtnTL};

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Two-flop synchroniser per button; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= btn_raw_c;
      sync2_q <= sync1_q;
    end
  end

  logic [3:0] pressed_c;
  logic       any_c;
  logic [1:0] color_c;
  logic       chord_c;

  assign pressed_c = ~sync2_q;
  assign any_c     = |pressed_c;

  // Priority colour encode for chords: TL, then BL, then TR, then BR.
  always_comb begin
    color_c = 2'd0;
    if (pressed_c[0]) begin
      color_c = 2'd0;
    end else if (pressed_c[2]) begin
      color_c = 2'd2;
    end else if (pressed_c[1]) begin
      color_c = 2'd1;
    end else if (pressed_c[3]) begin
      color_c = 2'd3;
    end
  end

`ifdef SIMON_STRICT_CHORD_EN
  // More than one bit set means two or more buttons are down together.
  assign chord_c = (pressed_c & (pressed_c - 4'd1)) != 4'd0;
`else
  assign chord_c = 1'b0;
`endif

  logic [2:0]       state_q,     state_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [DB_W-1:0]  db_cnt_q,    db_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
  logic [1:0]       cand_q,      cand_d;
  logic             match_q,     match_d;
  logic [1:0]       led_color_q, led_color_d;
  logic             led_en_q,    led_en_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             pass_q,      pass_d;
  logic             fail_q,      fail_d;
  logic             timeout_q,   timeout_d;

  logic             last_c;
  logic [DB_W-1:0]  db_inc_c;
  logic [TMO_W-1:0] tmo_inc_c;

  assign last_c    = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
  assign db_inc_c  = (db_cnt_q == DB_SAT) ? db_cnt_q : db_cnt_q + DB_W'(1);
  assign tmo_inc_c = (tmo_cnt_q == TMO_SAT) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);

  // Next-state and output logic of the round checker.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    db_cnt_d    = db_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    cand_d      = cand_q;
    match_d     = match_q;
    led_color_d = led_color_q;
    led_en_d    = led_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          idx_d     = '0;
          len_d     = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
          if (seq_len == '0) begin
            // An empty round is trivially passed.
            done_d = 1'b1;
            pass_d = 1'b1;
          end else begin
            busy_d    = 1'b1;
            tmo_cnt_d = '0;
            state_d   = S_WAIT_PRESS;
          end
        end
      end

      S_WAIT_PRESS: begin
        if (any_c) begin
          cand_d    = color_c;
          db_cnt_d  = '0;
          tmo_cnt_d = '0;
          state_d   = S_DB_DOWN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          done_d    = 1'b1;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_inc_c;
        end
      end

      S_DB_DOWN: begin
        if (chord_c) begin
          done_d   = 1'b1;
          fail_d   = 1'b1;
          led_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (!any_c) begin
          // Bounce or glitch: go back to waiting with a fresh timeout.
          tmo_cnt_d = '0;
          state_d   = S_WAIT_PRESS;
        end else if (color_c != cand_q) begin
          cand_d   = color_c;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          led_color_d = cand_q;
          led_en_d    = 1'b1;
          match_d     = (cand_q == exp_color);
          state_d     = S_HELD;
        end else begin
          db_cnt_d = db_inc_c;
        end
      end

      S_HELD: begin
        if (chord_c) begin
          done_d   = 1'b1;
          fail_d   = 1'b1;
          led_en_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (!any_c) begin
          db_cnt_d = '0;
          state_d  = S_DB_UP;
        end
      end

      S_DB_UP: begin
        if (any_c) begin
          // Release bounced; the same press is still in progress.
          db_cnt_d = '0;
          state_d  = S_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          led_en_d = 1'b0;
          if (!match_q) begin
            done_d  = 1'b1;
            fail_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else if (last_c) begin
            done_d  = 1'b1;
            pass_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tmo_cnt_d = '0;
            state_d   = S_WAIT_PRESS;
          end
        end else begin
          db_cnt_d = db_inc_c;
        end
      end

      default: begin
        busy_d   = 1'b0;
        led_en_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      db_cnt_q    <= '0;
      tmo_cnt_q   <= '0;
      cand_q      <= 2'd0;
      match_q     <= 1'b0;
      led_color_q <= 2'd0;
      led_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      db_cnt_q    <= db_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cand_q      <= cand_d;
      match_q     <= match_d;
      led_color_q <= led_color_d;
      led_en_q    <= led_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
    end
  end

  assign exp_idx   = idx_q;
  assign led_color = led_color_q;
  assign led_en    = led_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_simon_input_reader.sv
// Testbench for simon_input_reader with small debounce/timeout constants.
// The reference model is round-level: it compares the played colours against
// the stored sequence and predicts each accepted press and the result from
// button edge times plus a fixed synchroniser/debounce latency.
// Honours SIMON_STRICT_CHORD_EN for the chord cases.

module tb_simon_input_reader;

  localparam int unsigned DEB   = 4;
  localparam int unsigned TMO   = 100;
  localparam int unsigned MAXL  = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned LW    = IDX_W + 1;
  localparam int unsigned SYNC  = 2;
  // Raw button edge to registered effect: synchroniser, one detect cycle, debounce.
  localparam int          LAT   = SYNC + 1 + DEB;

  logic             clk = 1'b0;
  logic             reset;
  logic             btn_tl, btn_tr, btn_bl, btn_br;
  logic             start;
  logic [IDX_W:0]   seq_len;
  logic [IDX_W-1:0] exp_idx;
  logic [1:0]       exp_color;
  logic [1:0]       led_color;
  logic             led_en, busy, done, pass, fail, timeout;

  logic [1:0] seq_mem [MAXL];
  int         play    [MAXL];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign exp_color = seq_mem[exp_idx];

  simon_input_reader #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO),
    .MAX_LEN        (MAXL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .SimonBtnTL(btn_tl),
    .SimonBtnTR(btn_tr),
    .SimonBtnBL(btn_bl),
    .SimonBtnBR(btn_br),
    .start     (start),
    .seq_len   (seq_len),
    .exp_idx   (exp_idx),
    .exp_color (exp_color),
    .led_color (led_color),
    .led_en    (led_en),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timeout   (timeout)
  );

  // Event log sampled on the falling edge.
  int   rise_cyc[$];
  int   rise_col[$];
  int   rise_idx[$];
  int   done_cyc[$];
  int   done_pass[$];
  int   done_fail[$];
  int   done_tmo[$];
  int   done_busy[$];
  logic led_en_prev = 1'b0;

  always @(negedge clk) begin
    if (led_en && !led_en_prev) begin
      rise_cyc.push_back(cyc);
      rise_col.push_back(int'(led_color));
      rise_idx.push_back(int'(exp_idx));
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_pass.push_back(int'(pass));
      done_fail.push_back(int'(fail));
      done_tmo.push_back(int'(timeout));
      done_busy.push_back(int'(busy));
    end
    led_en_prev <= led_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // m bit c set means the button of colour c is pressed.
  task automatic set_btn(input logic [3:0] m);
    btn_tl = ~m[0];
    btn_tr = ~m[1];
    btn_bl = ~m[2];
    btn_br = ~m[3];
  endtask

  task automatic hold(input logic [3:0] m, input int n, output int t_on, output int t_off);
    set_btn(m);
    t_on = cyc;
    cycles(n);
    set_btn(4'b0000);
    t_off = cyc;
  endtask

  task automatic do_start(input int slen, output int t);
    start   = 1'b1;
    seq_len = LW'(slen);
    t       = cyc;
    cycles(1);
    start   = 1'b0;
  endtask

  task automatic clear_log();
    rise_cyc.delete();  rise_col.delete();  rise_idx.delete();
    done_cyc.delete();  done_pass.delete(); done_fail.delete();
    done_tmo.delete();  done_busy.delete();
  endtask

  function automatic logic [3:0] mask_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic expect_done(input string tag, input int t, input int p, input int f, input int to);
    chk({tag, ".ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk({tag, ".tdone"}, done_cyc[0], t);
      chk({tag, ".pass"},  done_pass[0], p);
      chk({tag, ".fail"},  done_fail[0], f);
      chk({tag, ".tmo"},   done_tmo[0], to);
      chk({tag, ".busy"},  done_busy[0], 0);
    end
  endtask

  // Plays play[] against seq_mem[]; the round ends at the first wrong colour
  // or after min(slen, MAXL) correct presses.
  task automatic play_round(input string tag, input int slen, input int fixed_hold);
    int len, n, ok, s, t_on, t_off, hl;
    int on_t [MAXL];
    len = (slen > int'(MAXL)) ? int'(MAXL) : slen;
    n   = 0;
    ok  = 1;
    for (int k = 0; k < len; k++) begin
      n = k + 1;
      if (play[k] != int'(seq_mem[k])) begin
        ok = 0;
        break;
      end
    end
    clear_log();
    t_off = 0;
    do_start(slen, s);
    for (int k = 0; k < n; k++) begin
      cycles(DEB + 2 + int'($urandom_range(8, 0)));
      hl = (fixed_hold > 0) ? fixed_hold : DEB + 2 + int'($urandom_range(10, 0));
      hold(mask_of(play[k]), hl, t_on, t_off);
      on_t[k] = t_on;
    end
    cycles(LAT + 4);
    chk({tag, ".nrise"}, rise_cyc.size(), n);
    for (int k = 0; k < n && k < rise_cyc.size(); k++) begin
      chk({tag, ".trise"}, rise_cyc[k], on_t[k] + LAT);
      chk({tag, ".color"}, rise_col[k], play[k]);
      chk({tag, ".idx"},   rise_idx[k], k);
    end
    if (n == 0) begin
      expect_done(tag, s + 1, 1, 0, 0);
      chk({tag, ".fidx"}, exp_idx, 0);
    end else begin
      expect_done(tag, t_off + LAT, ok, 1 - ok, 0);
      chk({tag, ".fidx"}, exp_idx, n - 1);
    end
    chk({tag, ".ledoff"}, led_en, 0);
  endtask

  task automatic chord_case(input string tag, input logic [3:0] m, input int c);
    int s, p, r;
    seq_mem[0] = 2'(c);
    clear_log();
    do_start(1, s);
    cycles(6);
    hold(m, 10, p, r);
    cycles(LAT + 4);
`ifdef SIMON_STRICT_CHORD_EN
    chk({tag, ".nrise"}, rise_cyc.size(), 0);
    chk({tag, ".ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) begin
      chk({tag, ".early"}, int'(done_cyc[0] < p + LAT), 1);
      chk({tag, ".fail"},  done_fail[0], 1);
      chk({tag, ".pass"},  done_pass[0], 0);
      chk({tag, ".tmo"},   done_tmo[0], 0);
    end
    chk({tag, ".ledoff"}, led_en, 0);
`else
    chk({tag, ".nrise"}, rise_cyc.size(), 1);
    if (rise_cyc.size() > 0) begin
      chk({tag, ".color"}, rise_col[0], c);
      chk({tag, ".trise"}, rise_cyc[0], p + LAT);
    end
    expect_done(tag, r + LAT, 1, 0, 0);
`endif
  endtask

  initial begin
    int s, p, r, p2, r2, slen, bad;
    reset   = 1'b1;
    start   = 1'b0;
    seq_len = '0;
    set_btn(4'b0000);
    for (int i = 0; i < int'(MAXL); i++) seq_mem[i] = 2'd0;
    cycles(3);
    chk("rst.idx", exp_idx, 0);
    chk("rst.lcol", led_color, 0);
    chk("rst.len", led_en, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pass", pass, 0);
    chk("rst.fail", fail, 0);
    chk("rst.tmo", timeout, 0);
    reset = 1'b0;
    cycles(2);

    // Correct three-entry round with fixed 10-cycle presses.
    seq_mem[0] = 2'd0; seq_mem[1] = 2'd2; seq_mem[2] = 2'd1;
    play[0] = 0; play[1] = 2; play[2] = 1;
    play_round("t1", 3, 10);

    // Second press wrong.
    seq_mem[0] = 2'd3; seq_mem[1] = 2'd3;
    play[0] = 3; play[1] = 0;
    play_round("t2", 2, 10);

    // No buttons: timeout.
    clear_log();
    do_start(2, s);
    cycles(TMO + 10);
    chk("t3.nrise", rise_cyc.size(), 0);
    expect_done("t3", s + 1 + TMO, 0, 1, 1);

    // Short glitch is rejected and restarts the timeout.
    clear_log();
    do_start(2, s);
    cycles(8);
    hold(mask_of(1), 2, p, r);
    cycles(6);
    chk("t4.nrise", rise_cyc.size(), 0);
    chk("t4.idx", exp_idx, 0);
    chk("t4.busy", busy, 1);
    chk("t4.ndone0", done_cyc.size(), 0);
    cycles(TMO + 10);
    expect_done("t4", r + SYNC + 1 + TMO, 0, 1, 1);

    // Empty round.
    play_round("t5a", 0, 0);

    // Start while busy is ignored; round then completes normally.
    seq_mem[0] = 2'd1; seq_mem[1] = 2'd2;
    clear_log();
    do_start(2, s);
    cycles(5);
    do_start(0, s);
    cycles(3);
    chk("t5b.ndone0", done_cyc.size(), 0);
    chk("t5b.busy", busy, 1);
    hold(mask_of(1), 9, p, r);
    cycles(DEB + 4);
    hold(mask_of(2), 9, p2, r2);
    cycles(LAT + 4);
    chk("t5b.nrise", rise_cyc.size(), 2);
    expect_done("t5b", r2 + LAT, 1, 0, 0);

    // Reset in the middle of a held press.
    seq_mem[0] = 2'd2; seq_mem[1] = 2'd0; seq_mem[2] = 2'd1;
    clear_log();
    do_start(3, s);
    cycles(6);
    set_btn(mask_of(2));
    cycles(LAT + 3);
    chk("t5c.held", led_en, 1);
    chk("t5c.hcol", led_color, 2);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    chk("t5c.idx", exp_idx, 0);
    chk("t5c.lcol", led_color, 0);
    chk("t5c.len", led_en, 0);
    chk("t5c.busy", busy, 0);
    chk("t5c.flags", {done, pass, fail, timeout}, 0);
    set_btn(4'b0000);
    cycles(LAT + 4);
    chk("t5c.ndone", done_cyc.size(), 0);

    // Release bounce during release debounce returns to the held press.
    seq_mem[0] = 2'd2;
    clear_log();
    do_start(1, s);
    cycles(6);
    hold(mask_of(2), 8, p, r);
    cycles(2);
    hold(mask_of(2), 8, p2, r2);
    cycles(LAT + 4);
    chk("bnc.nrise", rise_cyc.size(), 1);
    if (rise_cyc.size() > 0) chk("bnc.trise", rise_cyc[0], p + LAT);
    expect_done("bnc", r2 + LAT, 1, 0, 0);

    // Chords.
    chord_case("t6a", 4'b1001, 0);
    chord_case("t6b", 4'b0110, 2);

    // Length above MAX_LEN is clamped.
    for (int i = 0; i < int'(MAXL); i++) begin
      seq_mem[i] = 2'($urandom_range(3, 0));
      play[i]    = int'(seq_mem[i]);
    end
    play_round("sat", 12, 0);

    // Random rounds, some with one wrong press.
    for (int rr = 0; rr < 10; rr++) begin
      slen = int'($urandom_range(MAXL, 1));
      for (int i = 0; i < int'(MAXL); i++) begin
        seq_mem[i] = 2'($urandom_range(3, 0));
        play[i]    = int'(seq_mem[i]);
      end
      if ($urandom_range(2, 0) == 0) begin
        bad       = int'($urandom_range(slen - 1, 0));
        play[bad] = (play[bad] + 1 + int'($urandom_range(2, 0))) % 4;
      end
      play_round($sformatf("rnd%0d", rr), slen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
